// File: rtl/preg_free_list.sv
// Physical-register free list: ring of free tags, zero-latency head grant to rename, tail push from commit.
// Latency: alloc_tag/alloc_gnt combinational from head; a released tag becomes allocatable the cycle after release.
// Backpressure: stall whenever alloc_req is not granted (empty or still initialising); a release into a full list with no grant is dropped and flags err.
module preg_free_list #(
   parameter  int NUM_PREGS = 64,
   parameter  int NUM_AREGS = 32,
   parameter  int TAG_W     = $clog2(NUM_PREGS),
   localparam int DEPTH     = NUM_PREGS - NUM_AREGS,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_req,
   output logic             alloc_gnt,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             stall,
   input  logic             free_valid,
   input  logic [TAG_W-1:0] free_tag,
   output logic             ready,
   output logic             empty,
   output logic [CNT_W-1:0] free_count,
   output logic             err
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [TAG_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]   r_init_cnt;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [CNT_W-1:0]   r_count;
   logic               r_err;

   logic               w_run;
   logic               w_init;
   logic               w_init_last;
   logic               w_list_empty;
   logic               w_full;
   logic               w_fv_nz;
   logic               w_gnt;
   logic               w_accept;
   logic               w_err_set;

   // Next state and all combinational outputs; rst forces the post-reset output values.
   always_comb begin
      w_state_nxt  = r_state;
      w_run        = (r_state == ST_RUN) & ~rst;
      w_init       = (r_state == ST_INIT) & ~rst;
      w_init_last  = w_init & (r_init_cnt == PTR_W'(DEPTH - 1));
      w_list_empty = (r_count == '0);
      w_full       = (r_count == CNT_W'(DEPTH));
      w_fv_nz      = free_valid & (free_tag != '0);
      w_gnt        = w_run & alloc_req & ~w_list_empty;
      // A full list can still take a release when the head is being consumed in the same cycle.
      w_accept     = w_run & w_fv_nz & ~(w_full & ~w_gnt);
      w_err_set    = (w_init & free_valid) | (w_run & w_fv_nz & w_full & ~w_gnt);
      if (w_init_last) begin
         w_state_nxt = ST_RUN;
      end
      alloc_gnt  = w_gnt;
      alloc_tag  = r_mem[r_head];
      stall      = alloc_req & ~w_gnt;
      ready      = w_run;
      empty      = rst | w_list_empty;
      free_count = rst ? '0 : r_count;
      err        = r_err & ~rst;
   end

   // State, pointers, occupancy and sticky error; rst restarts initialisation from any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= r_err | w_err_set;
         if (w_init) begin
            r_init_cnt <= r_init_cnt + PTR_W'(1);
         end
         if (w_init_last) begin
            r_count <= CNT_W'(DEPTH);
         end else if (w_run) begin
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_gnt);
         end
         if (w_gnt) begin
            r_head <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
         end
         if (w_accept) begin
            r_tail <= (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);
         end
      end
   end

   // Tag storage: filled with the unmapped tags during init, then written at tail on each accepted release.
   always_ff @(posedge clk) begin
      if (w_init) begin
         r_mem[r_init_cnt] <= TAG_W'(NUM_AREGS) + TAG_W'(r_init_cnt);
      end else if (w_accept) begin
         r_mem[r_tail] <= free_tag;
      end
   end

endmodule
